micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Microprogram sequencer for the multicycle ARM control unit. It holds the 5-bit micro-program counter (uPC) and a 32-word control store, and drives every datapath control strobe for the current micro-step. It sends the raw next-address field to the op/funct dispatch resolver and registers the resolved address on the next clock edge.

## Interface
- No parameters. All widths are fixed by `ucode_pkg`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; uPC forced to 0 while low.
- `stall` in 1: memory not ready; hold the current micro-step.
- `resolved_adr` in 5: next address returned by the dispatch resolver.
- `next_field` out 5: raw next-address field of the current word, sent to the resolver.
- `upc` out 5: current micro-program counter.
- `adr_src` out 1; `alu_src_a` out 1; `alu_src_b` out 2; `alu_op` out 1; `result_src` out 2: datapath mux and ALU selects.
- `ir_write`, `next_pc`, `reg_w`, `mem_w`, `branch`, `link`, `byte_acc` out 1 each: datapath strobes.
- `ucode_err` out 1: unresolved dispatch code detected this cycle.

## Operation
- Control word fields:
  - `next`[4:0], adr_src, alu_src_a, alu_src_b[1:0], alu_op, result_src[1:0].
  - ir_write, next_pc, reg_w, mem_w, branch, link, byte_acc.
  - 19 bits total.
- All outputs are combinational reads of the control store at `upc`. `next_field` equals `word.next`.
- Store contents (addr name: non-zero fields; next):
  - 0 FETCH: alu_src_a=1, alu_src_b=10, result_src=10, ir_write=1, next_pc=1; next 1.
  - 1 DECODE: alu_src_a=1, alu_src_b=10, result_src=10; next 31 (decode dispatch).
  - 2 MEMADR: alu_src_b=01; next 30 (memory dispatch).
  - 3 MEMREAD: adr_src=1; next 4.
  - 4 MEMWB: result_src=01, reg_w=1; next 0.
  - 5 MEMWRITE: adr_src=1, mem_w=1; next 0.
  - 6 EXECUTER: alu_op=1; next 8.
  - 7 EXECUTEI: alu_src_b=01, alu_op=1; next 8.
  - 8 ALUWB: reg_w=1; next 0.
  - 9 BRANCH: alu_src_b=01, result_src=10, branch=1; next 0.
  - 10 BL: as BRANCH plus link=1, reg_w=1; next 0.
  - 11 MEMREADB: adr_src=1, byte_acc=1; next 4.
  - 12–31: all fields 0, next 0. These addresses are never legal uPC values.
- uPC update on each rising edge, in priority order:
  - `reset` low: uPC := 0.
  - `stall` = 1: uPC holds.
  - `resolved_adr` ∈ {30, 31}: uPC := 0 and `ucode_err` = 1. This is an unresolved dispatch.
  - Otherwise: uPC := `resolved_adr`.
- `ucode_err` is combinational on the current `resolved_adr` and is masked while `stall` = 1.
- While `stall` = 1, the architectural strobes are forced to 0: ir_write, next_pc, reg_w, mem_w, branch. Mux selects keep their store values.
- While `reset` is low, all strobes are forced to 0.
- After `reset` deasserts: `upc` = 0 and outputs show FETCH.

## Timing
- One micro-step per unstalled cycle.
- `resolved_adr` must settle within the same cycle as `next_field`; the resolver is purely combinational.
- Instruction latency in cycles, counted from FETCH:
  - LDR / LDRB: 5.
  - STR: 4.
  - Data-processing: 4.
  - B / BL: 3.
- Each stall cycle adds exactly one cycle; the stalled step's strobes fire only in its final unstalled cycle.
- Reset mid-instruction takes effect immediately (asynchronous), with no partial write on the reset edge.
- Stall and reset asserted together: reset wins.

## Structure
- `ucode_pkg` contains:
  - `ctrl_word_t` packed struct.
  - Named 5-bit address constants: `UA_FETCH` … `UA_MEMREADB`, `UA_DISP_DEC` = 31, `UA_DISP_MEM` = 30.
  - ALU-source and result-source encodings.
- One sub-module, `control_store`: a combinational 32×19 ROM implemented as a case on address, default word all zero.
- `micro_sequencer` holds only the uPC register, the stall/reset masking, and the error detect.

## Test plan
- Reset release, no stall, `resolved_adr` looped from the model resolver on an ADD-immediate → `upc` sequence 0,1,7,8,0; reg_w=1 only at step 8.
- LDR with `stall` high for 2 cycles in MEMREAD → `upc` holds 3 for 3 cycles; then 4, then 0; reg_w pulses once.
- STR → `upc` 0,1,2,5,0; mem_w=1 only at 5, adr_src=1.
- BL → `upc` 0,1,10,0; branch=1, link=1, reg_w=1 at 10.
- Force `resolved_adr` = 31 while in DECODE → `ucode_err`=1 that cycle and `upc`=0 next.
- Assert `reset` low asynchronously mid-MEMWRITE → `upc`=0 before the next edge, mem_w=0, no store issued.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared micro-code definitions: control word layout, micro-address map and
// datapath select encodings for the multicycle ARM control unit.
package ucode_pkg;

  typedef logic [4:0] uaddr_t;

  localparam uaddr_t UA_FETCH    = 5'd0;
  localparam uaddr_t UA_DECODE   = 5'd1;
  localparam uaddr_t UA_MEMADR   = 5'd2;
  localparam uaddr_t UA_MEMREAD  = 5'd3;
  localparam uaddr_t UA_MEMWB    = 5'd4;
  localparam uaddr_t UA_MEMWRITE = 5'd5;
  localparam uaddr_t UA_EXECUTER = 5'd6;
  localparam uaddr_t UA_EXECUTEI = 5'd7;
  localparam uaddr_t UA_ALUWB    = 5'd8;
  localparam uaddr_t UA_BRANCH   = 5'd9;
  localparam uaddr_t UA_BL       = 5'd10;
  localparam uaddr_t UA_MEMREADB = 5'd11;
  localparam uaddr_t UA_DISP_MEM = 5'd30;
  localparam uaddr_t UA_DISP_DEC = 5'd31;

  typedef enum logic {
    SRCA_REG = 1'b0,
    SRCA_PC  = 1'b1
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10
  } res_e;

  typedef struct packed {
    uaddr_t next;
    logic   adr_src;
    srca_e  alu_src_a;
    srcb_e  alu_src_b;
    logic   alu_op;
    res_e   result_src;
    logic   ir_write;
    logic   next_pc;
    logic   reg_w;
    logic   mem_w;
    logic   branch;
    logic   link;
    logic   byte_acc;
  } ctrl_word_t;

  // Dispatch codes must be replaced by the resolver; seeing one here is an error.
  function automatic logic is_dispatch(input uaddr_t a);
    return (a == UA_DISP_DEC) || (a == UA_DISP_MEM);
  endfunction

endpackage

// File: rtl/control_store.sv
// 32-word combinational micro-code ROM; unused addresses read as an all-zero word.
module control_store
  import ucode_pkg::*;
(
  input  logic [4:0] addr_i,
  output ctrl_word_t word_o
);

  // ROM contents, one micro-step per address.
  always_comb begin
    word_o = '0;
    case (addr_i)
      UA_FETCH: begin
        word_o.alu_src_a  = SRCA_PC;
        word_o.alu_src_b  = SRCB_FOUR;
        word_o.result_src = RES_ALU;
        word_o.ir_write   = 1'b1;
        word_o.next_pc    = 1'b1;
        word_o.next       = UA_DECODE;
      end
      UA_DECODE: begin
        word_o.alu_src_a  = SRCA_PC;
        word_o.alu_src_b  = SRCB_FOUR;
        word_o.result_src = RES_ALU;
        word_o.next       = UA_DISP_DEC;
      end
      UA_MEMADR: begin
        word_o.alu_src_b = SRCB_IMM;
        word_o.next      = UA_DISP_MEM;
      end
      UA_MEMREAD: begin
        word_o.adr_src = 1'b1;
        word_o.next    = UA_MEMWB;
      end
      UA_MEMWB: begin
        word_o.result_src = RES_DATA;
        word_o.reg_w      = 1'b1;
        word_o.next       = UA_FETCH;
      end
      UA_MEMWRITE: begin
        word_o.adr_src = 1'b1;
        word_o.mem_w   = 1'b1;
        word_o.next    = UA_FETCH;
      end
      UA_EXECUTER: begin
        word_o.alu_op = 1'b1;
        word_o.next   = UA_ALUWB;
      end
      UA_EXECUTEI: begin
        word_o.alu_src_b = SRCB_IMM;
        word_o.alu_op    = 1'b1;
        word_o.next      = UA_ALUWB;
      end
      UA_ALUWB: begin
        word_o.reg_w = 1'b1;
        word_o.next  = UA_FETCH;
      end
      UA_BRANCH: begin
        word_o.alu_src_b  = SRCB_IMM;
        word_o.result_src = RES_ALU;
        word_o.branch     = 1'b1;
        word_o.next       = UA_FETCH;
      end
      UA_BL: begin
        word_o.alu_src_b  = SRCB_IMM;
        word_o.result_src = RES_ALU;
        word_o.branch     = 1'b1;
        word_o.link       = 1'b1;
        word_o.reg_w      = 1'b1;
        word_o.next       = UA_FETCH;
      end
      UA_MEMREADB: begin
        word_o.adr_src  = 1'b1;
        word_o.byte_acc = 1'b1;
        word_o.next     = UA_MEMWB;
      end
      default: begin
        word_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: uPC register, stall/reset strobe masking and
// unresolved-dispatch detection around the control store.
module micro_sequencer
  import ucode_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [4:0] resolved_adr,
  output logic [4:0] next_field,
  output logic [4:0] upc,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op,
  output logic [1:0] result_src,
  output logic       ir_write,
  output logic       next_pc,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       link,
  output logic       byte_acc,
  output logic       ucode_err
);

  uaddr_t     upc_q;
  uaddr_t     upc_d;
  ctrl_word_t word_s;
  logic       arch_mask_s;
  logic       rst_mask_s;

  control_store u_store (
    .addr_i (upc_q),
    .word_o (word_s)
  );

  // Next uPC: hold on stall, fall back to FETCH on an unresolved dispatch code.
  always_comb begin
    upc_d = upc_q;
    if (stall) begin
      upc_d = upc_q;
    end else if (is_dispatch(resolved_adr)) begin
      upc_d = UA_FETCH;
    end else begin
      upc_d = resolved_adr;
    end
  end

  // uPC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc_q <= UA_FETCH;
    end else begin
      upc_q <= upc_d;
    end
  end

  // Reset kills every strobe; stall only kills those that change architectural state.
  assign rst_mask_s  = ~reset;
  assign arch_mask_s = ~reset | stall;

  assign upc        = upc_q;
  assign next_field = word_s.next;
  assign adr_src    = word_s.adr_src;
  assign alu_src_a  = word_s.alu_src_a;
  assign alu_src_b  = word_s.alu_src_b;
  assign alu_op     = word_s.alu_op;
  assign result_src = word_s.result_src;
  assign ir_write   = word_s.ir_write & ~arch_mask_s;
  assign next_pc    = word_s.next_pc  & ~arch_mask_s;
  assign reg_w      = word_s.reg_w    & ~arch_mask_s;
  assign mem_w      = word_s.mem_w    & ~arch_mask_s;
  assign branch     = word_s.branch   & ~arch_mask_s;
  assign link       = word_s.link     & ~rst_mask_s;
  assign byte_acc   = word_s.byte_acc & ~rst_mask_s;
  assign ucode_err  = ~stall & is_dispatch(resolved_adr);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer with a behavioural dispatch resolver.
module tb_micro_sequencer;

  localparam int I_ADDI = 0;
  localparam int I_ADDR = 1;
  localparam int I_LDR  = 2;
  localparam int I_LDRB = 3;
  localparam int I_STR  = 4;
  localparam int I_B    = 5;
  localparam int I_BL   = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [4:0] resolved_adr;
  logic [4:0] next_field;
  logic [4:0] upc;
  logic       adr_src, alu_src_a, alu_op;
  logic [1:0] alu_src_b, result_src;
  logic       ir_write, next_pc, reg_w, mem_w, branch, link, byte_acc;
  logic       ucode_err;

  int         instr;
  logic       force_en;
  logic [4:0] force_val;
  int         n_checks = 0;
  int         n_fail = 0;

  micro_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .resolved_adr (resolved_adr),
    .next_field   (next_field),
    .upc          (upc),
    .adr_src      (adr_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .result_src   (result_src),
    .ir_write     (ir_write),
    .next_pc      (next_pc),
    .reg_w        (reg_w),
    .mem_w        (mem_w),
    .branch       (branch),
    .link         (link),
    .byte_acc     (byte_acc),
    .ucode_err    (ucode_err)
  );

  always #5 clk = ~clk;

  // Model resolver: maps the two dispatch codes by instruction class.
  always_comb begin
    resolved_adr = next_field;
    if (force_en) begin
      resolved_adr = force_val;
    end else if (next_field == 5'd31) begin
      case (instr)
        I_ADDI:  resolved_adr = 5'd7;
        I_ADDR:  resolved_adr = 5'd6;
        I_B:     resolved_adr = 5'd9;
        I_BL:    resolved_adr = 5'd10;
        default: resolved_adr = 5'd2;
      endcase
    end else if (next_field == 5'd30) begin
      case (instr)
        I_LDR:   resolved_adr = 5'd3;
        I_LDRB:  resolved_adr = 5'd11;
        default: resolved_adr = 5'd5;
      endcase
    end else begin
      resolved_adr = next_field;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle and check uPC and the register-write strobe.
  task automatic step(input string tag, input logic [4:0] exp_upc, input logic exp_regw);
    @(negedge clk);
    check({tag, " upc"}, upc, exp_upc);
    check({tag, " reg_w"}, reg_w, exp_regw);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b1;
    instr = I_ADDI;
    force_en = 1'b0;
    force_val = 5'd0;
    repeat (2) @(negedge clk);
    check("rst upc", upc, 5'd0);
    check("rst ir_write masked", ir_write, 1'b0);
    check("rst next_pc masked", next_pc, 1'b0);
    stall = 1'b0;
    reset = 1'b1;
    #1;
    check("fetch upc", upc, 5'd0);
    check("fetch ir_write", ir_write, 1'b1);
    check("fetch next_pc", next_pc, 1'b1);
    check("fetch alu_src_a", alu_src_a, 1'b1);
    check("fetch alu_src_b", alu_src_b, 2'b10);
    check("fetch result_src", result_src, 2'b10);
    check("fetch next_field", next_field, 5'd1);

    // ADD immediate: 0,1,7,8,0
    step("addi decode", 5'd1, 1'b0);
    check("decode next_field", next_field, 5'd31);
    check("decode ucode_err", ucode_err, 1'b0);
    step("addi exec", 5'd7, 1'b0);
    check("execi alu_src_b", alu_src_b, 2'b01);
    check("execi alu_op", alu_op, 1'b1);
    step("addi aluwb", 5'd8, 1'b1);
    step("addi fetch", 5'd0, 1'b0);

    // LDR with a two-cycle stall in MEMREAD
    instr = I_LDR;
    step("ldr decode", 5'd1, 1'b0);
    step("ldr memadr", 5'd2, 1'b0);
    check("memadr next_field", next_field, 5'd30);
    step("ldr memread", 5'd3, 1'b0);
    check("memread adr_src", adr_src, 1'b1);
    stall = 1'b1;
    step("ldr stall1", 5'd3, 1'b0);
    step("ldr stall2", 5'd3, 1'b0);
    stall = 1'b0;
    step("ldr memwb", 5'd4, 1'b1);
    check("memwb result_src", result_src, 2'b01);
    step("ldr fetch", 5'd0, 1'b0);

    // STR, stalled in FETCH and DECODE first
    instr = I_STR;
    stall = 1'b1;
    #1;
    check("stall fetch ir_write", ir_write, 1'b0);
    check("stall fetch next_pc", next_pc, 1'b0);
    check("stall fetch alu_src_b", alu_src_b, 2'b10);
    step("str fetch held", 5'd0, 1'b0);
    stall = 1'b0;
    step("str decode", 5'd1, 1'b0);
    stall = 1'b1;
    force_en = 1'b1;
    force_val = 5'd31;
    #1;
    check("stall masks ucode_err", ucode_err, 1'b0);
    step("str decode held", 5'd1, 1'b0);
    stall = 1'b0;
    force_en = 1'b0;
    step("str memadr", 5'd2, 1'b0);
    step("str memwrite", 5'd5, 1'b0);
    check("str mem_w", mem_w, 1'b1);
    check("str adr_src", adr_src, 1'b1);
    step("str fetch", 5'd0, 1'b0);
    check("str fetch mem_w", mem_w, 1'b0);

    // BL: 0,1,10,0
    instr = I_BL;
    step("bl decode", 5'd1, 1'b0);
    step("bl exec", 5'd10, 1'b1);
    check("bl branch", branch, 1'b1);
    check("bl link", link, 1'b1);
    check("bl alu_src_b", alu_src_b, 2'b01);
    step("bl fetch", 5'd0, 1'b0);
    check("bl fetch link", link, 1'b0);

    // LDRB goes through MEMREADB
    instr = I_LDRB;
    step("ldrb decode", 5'd1, 1'b0);
    step("ldrb memadr", 5'd2, 1'b0);
    step("ldrb memreadb", 5'd11, 1'b0);
    check("ldrb byte_acc", byte_acc, 1'b1);
    step("ldrb memwb", 5'd4, 1'b1);
    step("ldrb fetch", 5'd0, 1'b0);

    // Forced unresolved dispatch while in DECODE
    instr = I_ADDR;
    step("err decode", 5'd1, 1'b0);
    force_en = 1'b1;
    force_val = 5'd31;
    #1;
    check("err ucode_err", ucode_err, 1'b1);
    step("err recover", 5'd0, 1'b0);
    force_val = 5'd30;
    #1;
    check("err30 ucode_err", ucode_err, 1'b1);
    force_en = 1'b0;
    #1;
    check("err cleared", ucode_err, 1'b0);

    // Asynchronous reset mid-MEMWRITE, with stall also high
    instr = I_STR;
    step("rst2 decode", 5'd1, 1'b0);
    step("rst2 memadr", 5'd2, 1'b0);
    step("rst2 memwrite", 5'd5, 1'b0);
    check("rst2 mem_w before", mem_w, 1'b1);
    #1;
    reset = 1'b0;
    stall = 1'b1;
    #1;
    check("async rst upc", upc, 5'd0);
    check("async rst mem_w", mem_w, 1'b0);
    check("async rst adr_src", adr_src, 1'b0);
    check("async rst ir_write", ir_write, 1'b0);
    @(posedge clk);
    #1;
    check("rst held upc", upc, 5'd0);
    check("rst held mem_w", mem_w, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    #1;
    check("post rst ir_write", ir_write, 1'b1);
    step("post rst decode", 5'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
